// File: rtl/spi_master_xfer_pkg.sv
// Shared definitions for the SPI master: transfer FSM state encoding and the
// divider width default that the register block also uses.
package spi_master_xfer_pkg;

  localparam int unsigned SPI_DIV_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_NEXT,
    ST_END
  } xfer_state_e;

endpackage

// File: rtl/spi_master_xfer_sclk_gen.sv
// SCLK generator: divider counter, registered sclk and one-cycle rise/fall
// strobes that flag the toggle happening at the end of the current cycle.
module spi_master_sclk_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             rise,
  output logic             fall
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  // Divider count 0..div; toggle sclk and flag the edge at terminal count.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    rise   = 1'b0;
    fall   = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en) begin
      if (cnt_q == div) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
        rise   = ~sclk_q;
        fall   = sclk_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Divider and sclk registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_xfer.sv
// SPI mode-0 transfer engine: reads words from the TX buffer, shifts them out
// MSB first while capturing MISO, and writes each received word to the RX
// buffer at the same index.
module spi_master_xfer
  import spi_master_xfer_pkg::*;
#(
  parameter int unsigned BUF_DW = 16,
  parameter int unsigned BUF_AW = 5,
  parameter int unsigned DIV_W  = SPI_DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BUF_AW:0]   count,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [BUF_AW-1:0] tx_addr,
  input  logic [BUF_DW-1:0] tx_data,
  output logic              rx_we,
  output logic [BUF_AW-1:0] rx_addr,
  output logic [BUF_DW-1:0] rx_data,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned   BCW   = $clog2(BUF_DW + 1);
  localparam logic [BUF_AW:0] DEPTH = {1'b1, {BUF_AW{1'b0}}};

  xfer_state_e       state_q, state_d;
  logic [BUF_AW:0]   n_q, n_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  end_cnt_q, end_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BUF_DW-1:0] tx_sr_q, tx_sr_d;
  logic [BUF_DW-1:0] rx_sr_q, rx_sr_d;
  logic [BUF_AW-1:0] tx_addr_q, tx_addr_d;
  logic [BUF_AW-1:0] rx_addr_q, rx_addr_d;
  logic [BUF_DW-1:0] rx_data_q, rx_data_d;
  logic              rx_we_q, rx_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;

  logic              gen_clr, gen_en, sclk_rise, sclk_fall;
  logic              words_left;

  assign gen_clr = (state_q == ST_LOAD);
  assign gen_en  = (state_q == ST_SHIFT);

  spi_master_sclk_gen #(
    .DIV_W (DIV_W)
  ) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (gen_clr),
    .en   (gen_en),
    .div  (div_q),
    .sclk (spi_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // tx_addr doubles as the word index; it stops at n-1 and never wraps.
  assign words_left = (({1'b0, tx_addr_q} + (BUF_AW+1)'(1)) < n_q);

  // Next-state and datapath updates for the transfer FSM.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    div_d     = div_q;
    end_cnt_d = end_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    tx_addr_d = tx_addr_q;
    rx_addr_d = rx_addr_q;
    rx_data_d = rx_data_q;
    rx_we_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            n_d       = (count > DEPTH) ? DEPTH : count;
            div_d     = clk_div;
            tx_addr_d = '0;
            cs_n_d    = 1'b0;
            busy_d    = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        tx_sr_d   = tx_data;
        mosi_d    = tx_data[BUF_DW-1];
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (sclk_rise) begin
          rx_sr_d   = {rx_sr_q[BUF_DW-2:0], spi_miso};
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
        if (sclk_fall) begin
          // The received word is complete well before the final fall, so the
          // RX write is registered here and appears during NEXT.
          if (bit_cnt_q == BCW'(BUF_DW)) begin
            rx_we_d   = 1'b1;
            rx_addr_d = tx_addr_q;
            rx_data_d = rx_sr_q;
            state_d   = ST_NEXT;
          end else begin
            tx_sr_d = tx_sr_q << 1;
            mosi_d  = tx_sr_q[BUF_DW-2];
          end
        end
      end

      ST_NEXT: begin
        if (words_left) begin
          tx_addr_d = tx_addr_q + BUF_AW'(1);
          state_d   = ST_FETCH;
        end else begin
          cs_n_d    = 1'b1;
          end_cnt_d = '0;
          state_d   = ST_END;
        end
      end

      ST_END: begin
        // CS-high hold of div+1 cycles, then the registered done cycle.
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (end_cnt_q == div_q) begin
          done_d = 1'b1;
        end else begin
          end_cnt_d = end_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      div_q     <= '0;
      end_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      tx_addr_q <= '0;
      rx_addr_q <= '0;
      rx_data_q <= '0;
      rx_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      div_q     <= div_d;
      end_cnt_q <= end_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      tx_addr_q <= tx_addr_d;
      rx_addr_q <= rx_addr_d;
      rx_data_q <= rx_data_d;
      rx_we_q   <= rx_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_addr  = tx_addr_q;
  assign rx_we    = rx_we_q;
  assign rx_addr  = rx_addr_q;
  assign rx_data  = rx_data_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Randomized self-checking bench for spi_master_xfer with a behavioural model
// of the TX/RX buffers, an MISO loopback (optionally inverted) and monitors
// for the mode-0 SPI rules.
module tb_spi_master_xfer;

  localparam int DW   = 16;
  localparam int AW   = 5;
  localparam int DIVW = 8;
  localparam int DEP  = 1 << AW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW:0]     count;
  logic [DIVW-1:0] clk_div;
  logic            busy, done;
  logic [AW-1:0]   tx_addr;
  logic [DW-1:0]   tx_data;
  logic            rx_we;
  logic [AW-1:0]   rx_addr;
  logic [DW-1:0]   rx_data;
  logic            spi_cs_n, spi_sclk, spi_mosi, spi_miso;
  logic            miso_inv;

  logic [DW-1:0]   tx_mem [DEP];

  int n_checks = 0;
  int n_errors = 0;

  // monitor state
  bit   bits[$];
  int   wr_addr[$];
  int   wr_data[$];
  int   done_cnt, mosi_viol, cs_viol;
  bit   busy_seen, cs_seen;
  logic sclk_prev, mosi_prev;

  always #5 clk = ~clk;

  spi_master_xfer #(
    .BUF_DW (DW),
    .BUF_AW (AW),
    .DIV_W  (DIVW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count    (count),
    .clk_div  (clk_div),
    .busy     (busy),
    .done     (done),
    .tx_addr  (tx_addr),
    .tx_data  (tx_data),
    .rx_we    (rx_we),
    .rx_addr  (rx_addr),
    .rx_data  (rx_data),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  // TX buffer model: registered read, one cycle latency
  always @(posedge clk) tx_data <= tx_mem[tx_addr];

  assign spi_miso = spi_mosi ^ miso_inv;

  // Observe pins mid-cycle
  always @(negedge clk) begin
    if (spi_sclk && !sclk_prev) begin
      if (spi_mosi !== mosi_prev) mosi_viol++;
      bits.push_back(spi_mosi);
    end
    if (spi_cs_n && spi_sclk) cs_viol++;
    if (rx_we) begin
      wr_addr.push_back(int'(rx_addr));
      wr_data.push_back(int'(rx_data));
    end
    if (done) done_cnt++;
    if (busy) busy_seen = 1'b1;
    if (!spi_cs_n) cs_seen = 1'b1;
    sclk_prev = spi_sclk;
    mosi_prev = spi_mosi;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon;
    bits.delete();
    wr_addr.delete();
    wr_data.delete();
    done_cnt  = 0;
    mosi_viol = 0;
    cs_viol   = 0;
    busy_seen = 1'b0;
    cs_seen   = 1'b0;
  endtask

  task automatic fill_mem;
    for (int i = 0; i < DEP; i++) tx_mem[i] = DW'($urandom);
  endtask

  // One transfer of cnt words; poke>0 pulses start at that busy cycle.
  task automatic run_xfer(input int cnt, input int div, input bit inv, input int poke);
    int n, exp_cyc, cyc;
    logic [DW-1:0] w, mask;
    n       = (cnt > DEP) ? DEP : cnt;
    exp_cyc = n * (2 * DW * (div + 1) + 3) + (div + 1) + 1;
    mask    = inv ? '1 : '0;
    clear_mon();
    miso_inv = inv;
    tick;
    start   = 1'b1;
    count   = (AW+1)'(cnt);
    clk_div = DIVW'(div);
    tick;
    start   = 1'b0;
    clk_div = DIVW'($urandom);
    cyc     = 1;
    check_eq("busy_first", 32'(busy), 1);
    check_eq("cs_low_first", 32'(spi_cs_n), 0);
    while (!done && cyc < exp_cyc + 100) begin
      tick;
      cyc++;
      start = (poke != 0 && cyc == poke);
      if (start) count = (AW+1)'($urandom_range(1, 8));
    end
    start = 1'b0;
    check_eq("done_cycle", 32'(cyc), 32'(exp_cyc));
    check_eq("busy_at_done", 32'(busy), 1);
    check_eq("tx_addr_end", 32'(tx_addr), 32'(n - 1));
    tick;
    check_eq("busy_after", 32'(busy), 0);
    check_eq("cs_after", 32'(spi_cs_n), 1);
    repeat (4) tick;
    check_eq("done_pulses", 32'(done_cnt), 1);
    check_eq("rx_writes", 32'(wr_addr.size()), 32'(n));
    check_eq("sclk_rises", 32'(bits.size()), 32'(n * DW));
    check_eq("mosi_stable", 32'(mosi_viol), 0);
    check_eq("sclk_cs_high", 32'(cs_viol), 0);
    for (int i = 0; i < n; i++) begin
      if (i < wr_addr.size()) begin
        check_eq("rx_addr", 32'(wr_addr[i]), 32'(i));
        check_eq("rx_data", 32'(wr_data[i]), 32'(tx_mem[i] ^ mask));
      end
      if ((i + 1) * DW <= bits.size()) begin
        w = '0;
        for (int b = 0; b < DW; b++) w = {w[DW-2:0], bits[i*DW + b]};
        check_eq("mosi_word", 32'(w), 32'(tx_mem[i]));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; clk_div = '0; miso_inv = 1'b0;
    fill_mem();
    clear_mon();
    repeat (3) tick;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_rx_we", 32'(rx_we), 0);
    check_eq("rst_tx_addr", 32'(tx_addr), 0);
    check_eq("rst_rx_addr", 32'(rx_addr), 0);
    check_eq("rst_rx_data", 32'(rx_data), 0);
    check_eq("rst_cs_n", 32'(spi_cs_n), 1);
    check_eq("rst_sclk", 32'(spi_sclk), 0);
    check_eq("rst_mosi", 32'(spi_mosi), 0);
    rst = 1'b0;
    tick;

    // Loopback 2 words, clk_div=1: done at cycle 2*67+2+1 = 137
    tx_mem[0] = 16'hA55A;
    tx_mem[1] = 16'h0F0F;
    run_xfer(2, 1, 1'b0, 0);

    // count = 0
    clear_mon();
    tick;
    start = 1'b1; count = '0; clk_div = 8'd3;
    tick;
    start = 1'b0;
    check_eq("zero_done", 32'(done), 1);
    check_eq("zero_busy", 32'(busy), 0);
    tick;
    check_eq("zero_done_once", 32'(done), 0);
    repeat (5) tick;
    check_eq("zero_busy_seen", 32'(busy_seen), 0);
    check_eq("zero_cs_seen", 32'(cs_seen), 0);
    check_eq("zero_rises", 32'(bits.size()), 0);
    check_eq("zero_writes", 32'(wr_addr.size()), 0);
    check_eq("zero_done_cnt", 32'(done_cnt), 1);

    // Random transfers, clk_div from {0,3,7}, inverted or plain loopback
    for (int t = 0; t < 5; t++) begin
      int sel;
      fill_mem();
      sel = $urandom_range(0, 2);
      run_xfer($urandom_range(1, 5), (sel == 0) ? 0 : (sel == 1) ? 3 : 7,
               1'($urandom_range(0, 1)), 0);
    end

    // Oversized count clamps to the buffer depth
    fill_mem();
    run_xfer(DEP + 5, 0, 1'b1, 0);

    // start pulsed during SHIFT of a 1-word transfer
    fill_mem();
    run_xfer(1, 2, 1'b0, 20);

    // Reset during word 1, bit 7
    begin
      int cyc;
      fill_mem();
      clear_mon();
      miso_inv = 1'b0;
      tick;
      start = 1'b1; count = 6'd3; clk_div = 8'd1;
      tick;
      start = 1'b0;
      cyc = 0;
      while (bits.size() < DW + 7 && cyc < 1000) begin
        tick;
        cyc++;
      end
      check_eq("rst_wait", 32'(bits.size()), 32'(DW + 7));
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_eq("mid_rst_cs", 32'(spi_cs_n), 1);
      check_eq("mid_rst_sclk", 32'(spi_sclk), 0);
      check_eq("mid_rst_busy", 32'(busy), 0);
      check_eq("mid_rst_we", 32'(rx_we), 0);
      repeat (40) tick;
      check_eq("mid_rst_writes", 32'(wr_addr.size()), 1);
      check_eq("mid_rst_idle", 32'(busy), 0);
      check_eq("mid_rst_done", 32'(done_cnt), 0);
    end
    fill_mem();
    run_xfer(2, 0, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
